// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
//
// Contents:
//   uart_rx_state_t     - receiver FSM states (IDLE, START, DATA, STOP)
//   UART_DATA_BITS      - payload bits per frame (8N1)
//   UART_MIN_BIT_PERIOD - smallest usable clocks-per-bit value
//   clamp_period()      - applies the minimum bit period to a programmed value
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_rx_state_t;

   localparam int          UART_DATA_BITS      = 8;
   localparam logic [15:0] UART_MIN_BIT_PERIOD = 16'd4;

   // Periods below the minimum leave no room for a meaningful half-bit
   // offset, so both ends of the link round them up to the same floor.
   function automatic logic [15:0] clamp_period(input logic [15:0] period);
      return (period < UART_MIN_BIT_PERIOD) ? UART_MIN_BIT_PERIOD : period;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for an asynchronous single-bit input.
// Flops reset to 1 so an idle-high line never shows a spurious edge out of reset.
//
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   din  - asynchronous input
//   dout - synchronized output (STAGES cycles of latency)
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout
);

   logic [STAGES-1:0] sync_q;

   // Shift chain: din enters at bit 0, the settled value leaves at the top.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
      end
   end

   assign dout = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. Synchronizes serial_in, detects the start edge, samples
// each bit at its midpoint and presents each good byte with a one-cycle pulse.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   bit_period - clocks per bit (latched at start detection, min 4)
//   serial_in  - asynchronous serial line, idle high
//   data       - last correctly framed byte
//   rx_valid   - one-cycle pulse when data updates
//   rx_busy    - high while a frame is in progress
//   frame_err  - one-cycle pulse when the stop bit samples low
module uart_rx
   import uart_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] bit_period,
   input  logic        serial_in,
   output logic [7:0]  data,
   output logic        rx_valid,
   output logic        rx_busy,
   output logic        frame_err
);

   uart_rx_state_t state, state_next;

   logic        line_s;
   logic        line_d;
   logic        fall;
   logic [15:0] cnt, cnt_next;
   logic [15:0] period_q, period_next;
   logic [15:0] target;
   logic        strobe;
   logic [2:0]  idx, idx_next;
   logic [UART_DATA_BITS-1:0] shift_q, shift_next;
   logic [7:0]  data_next;
   logic        valid_next;
   logic        err_next;

   uart_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst  (rst),
      .din  (serial_in),
      .dout (line_s)
   );

   // Only a 1->0 transition starts a frame, so a line stuck low stays quiet.
   assign fall = line_d & ~line_s;

   // START waits half a bit to land mid start-bit; later states step a full bit.
   always_comb begin
      target = period_q;
      if (state == START) begin
         target = period_q >> 1;
      end
   end

   assign strobe  = (state != IDLE) && (cnt == target - 16'd1);
   assign rx_busy = (state != IDLE);

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (fall) begin
               state_next = START;
            end
         end
         START: begin
            if (strobe) begin
               state_next = line_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (strobe && (idx == 3'(UART_DATA_BITS - 1))) begin
               state_next = STOP;
            end
         end
         STOP: begin
            if (strobe) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath and output logic. The counter restarts on every state entry and
   // on every strobe so that consecutive data bits each get a full period.
   always_comb begin
      cnt_next    = cnt + 16'd1;
      period_next = period_q;
      idx_next    = idx;
      shift_next  = shift_q;
      data_next   = data;
      valid_next  = 1'b0;
      err_next    = 1'b0;

      if ((state_next != state) || strobe) begin
         cnt_next = 16'd0;
      end

      case (state)
         IDLE: begin
            if (fall) begin
               period_next = clamp_period(bit_period);
               idx_next    = 3'd0;
            end
         end
         START: begin
            if (strobe) begin
               idx_next = 3'd0;
            end
         end
         DATA: begin
            if (strobe) begin
               shift_next = {line_s, shift_q[UART_DATA_BITS-1:1]};
               idx_next   = idx + 3'd1;
            end
         end
         STOP: begin
            if (strobe) begin
               if (line_s) begin
                  data_next  = shift_q;
                  valid_next = 1'b1;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         default: begin
         end
      endcase
   end

   // All state, including the registered output pulses and edge history.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         line_d    <= 1'b1;
         cnt       <= 16'd0;
         period_q  <= UART_MIN_BIT_PERIOD;
         idx       <= 3'd0;
         shift_q   <= '0;
         data      <= 8'h00;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_next;
         line_d    <= line_s;
         cnt       <= cnt_next;
         period_q  <= period_next;
         idx       <= idx_next;
         shift_q   <= shift_next;
         data      <= data_next;
         rx_valid  <= valid_next;
         frame_err <= err_next;
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: drives 8N1 frames from a simple
// transmitter model and checks received bytes, pulses and busy duration.
module tb_uart_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] bit_period;
   logic        serial_in;
   logic [7:0]  data;
   logic        rx_valid;
   logic        rx_busy;
   logic        frame_err;

   int checks = 0;
   int errors = 0;

   int valid_cnt;
   int err_cnt;
   int busy_cnt;
   int both_cnt   = 0;
   int double_cnt = 0;
   int vbusy_cnt  = 0;
   logic prev_valid = 1'b0;
   logic prev_err   = 1'b0;
   logic [7:0] rx_q[$];

   uart_rx #(
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bit_period (bit_period),
      .serial_in  (serial_in),
      .data       (data),
      .rx_valid   (rx_valid),
      .rx_busy    (rx_busy),
      .frame_err  (frame_err)
   );

   always #5 clk = ~clk;

   // Pulse and busy monitor, sampled mid-cycle away from the active edge.
   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt = valid_cnt + 1;
         rx_q.push_back(data);
         if (rx_busy) vbusy_cnt = vbusy_cnt + 1;
      end
      if (frame_err) err_cnt = err_cnt + 1;
      if (rx_busy) busy_cnt = busy_cnt + 1;
      if (rx_valid && frame_err) both_cnt = both_cnt + 1;
      if ((rx_valid && prev_valid) || (frame_err && prev_err)) double_cnt = double_cnt + 1;
      prev_valid = rx_valid;
      prev_err   = frame_err;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clearCounts();
      valid_cnt = 0;
      err_cnt   = 0;
      busy_cnt  = 0;
      rx_q.delete();
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Transmitter model: start bit, 8 data bits LSB first, stop bit, each
   // held for the clamped period. The line is left at the stop-bit level.
   task automatic applyStimulus(input logic [7:0] b, input int p, input logic stop_bit);
      int pe;
      pe = (p < 4) ? 4 : p;
      serial_in = 1'b0;
      tick(pe);
      for (int i = 0; i < 8; i++) begin
         serial_in = b[i];
         tick(pe);
      end
      serial_in = stop_bit;
      tick(pe);
   endtask

   initial begin
      rst        = 1'b1;
      serial_in  = 1'b1;
      bit_period = 16'd16;
      valid_cnt  = 0;
      err_cnt    = 0;
      busy_cnt   = 0;
      tick(3);
      checkOutput("reset_data", 32'(data), 32'h00);
      checkOutput("reset_valid", 32'(rx_valid), 32'h0);
      checkOutput("reset_busy", 32'(rx_busy), 32'h0);
      checkOutput("reset_ferr", 32'(frame_err), 32'h0);
      rst = 1'b0;
      tick(5);
      checkOutput("idle_busy", 32'(rx_busy), 32'h0);

      // Single frame 0xA5 at 16 clocks/bit: busy for H + 9P = 152 cycles.
      $display("[TB] frame 0xA5");
      clearCounts();
      applyStimulus(8'hA5, 16, 1'b1);
      tick(20);
      checkOutput("a5_valid_count", 32'(valid_cnt), 32'd1);
      checkOutput("a5_data", 32'(data), 32'hA5);
      checkOutput("a5_queue", 32'(rx_q[0]), 32'hA5);
      checkOutput("a5_ferr_count", 32'(err_cnt), 32'd0);
      checkOutput("a5_busy_cycles", 32'(busy_cnt), 32'd152);

      // 4-cycle low glitch: START lasts H = 8 cycles then aborts silently.
      $display("[TB] start-bit glitch");
      clearCounts();
      serial_in = 1'b0;
      tick(4);
      serial_in = 1'b1;
      tick(40);
      checkOutput("glitch_busy_cycles", 32'(busy_cnt), 32'd8);
      checkOutput("glitch_valid_count", 32'(valid_cnt), 32'd0);
      checkOutput("glitch_ferr_count", 32'(err_cnt), 32'd0);
      checkOutput("glitch_data", 32'(data), 32'hA5);

      // 0x11 good, then 0x3C with low stop bit, line held low afterwards.
      $display("[TB] framing error");
      clearCounts();
      applyStimulus(8'h11, 16, 1'b1);
      applyStimulus(8'h3C, 16, 1'b0);
      tick(100);
      checkOutput("ferr_valid_count", 32'(valid_cnt), 32'd1);
      checkOutput("ferr_first_byte", 32'(rx_q[0]), 32'h11);
      checkOutput("ferr_count", 32'(err_cnt), 32'd1);
      checkOutput("ferr_data_kept", 32'(data), 32'h11);
      busy_cnt = 0;
      tick(50);
      checkOutput("low_line_no_retrigger", 32'(busy_cnt), 32'd0);
      serial_in = 1'b1;
      tick(10);
      applyStimulus(8'h7E, 16, 1'b1);
      tick(20);
      checkOutput("after_low_data", 32'(data), 32'h7E);
      checkOutput("after_low_valid_count", 32'(valid_cnt), 32'd2);

      // Back-to-back frames at 10 clocks/bit with no idle gap.
      $display("[TB] back-to-back frames");
      clearCounts();
      bit_period = 16'd10;
      applyStimulus(8'h00, 10, 1'b1);
      applyStimulus(8'hFF, 10, 1'b1);
      applyStimulus(8'h80, 10, 1'b1);
      tick(20);
      checkOutput("b2b_valid_count", 32'(valid_cnt), 32'd3);
      checkOutput("b2b_byte0", 32'(rx_q[0]), 32'h00);
      checkOutput("b2b_byte1", 32'(rx_q[1]), 32'hFF);
      checkOutput("b2b_byte2", 32'(rx_q[2]), 32'h80);
      checkOutput("b2b_ferr_count", 32'(err_cnt), 32'd0);

      // Reset during data bit 3 of 0xC3.
      $display("[TB] reset mid-frame");
      clearCounts();
      bit_period = 16'd16;
      serial_in = 1'b0;
      tick(16);
      serial_in = 1'b1;
      tick(16);
      serial_in = 1'b1;
      tick(16);
      serial_in = 1'b0;
      tick(16);
      serial_in = 1'b0;
      tick(8);
      checkOutput("midframe_busy", 32'(rx_busy), 32'h1);
      rst = 1'b1;
      serial_in = 1'b1;
      tick(1);
      checkOutput("midrst_data", 32'(data), 32'h00);
      checkOutput("midrst_busy", 32'(rx_busy), 32'h0);
      checkOutput("midrst_valid", 32'(rx_valid), 32'h0);
      checkOutput("midrst_ferr", 32'(frame_err), 32'h0);
      rst = 1'b0;
      tick(200);
      checkOutput("midrst_no_pulse", 32'(valid_cnt + err_cnt), 32'd0);
      applyStimulus(8'h5A, 16, 1'b1);
      tick(20);
      checkOutput("post_rst_data", 32'(data), 32'h5A);
      checkOutput("post_rst_valid_count", 32'(valid_cnt), 32'd1);

      // Loopback from the transmitter model at 8 and then 2 (clamped to 4).
      $display("[TB] loopback");
      clearCounts();
      bit_period = 16'd8;
      for (int b = 1; b <= 16; b++) applyStimulus(8'(b), 8, 1'b1);
      bit_period = 16'd2;
      for (int b = 1; b <= 16; b++) applyStimulus(8'(b), 2, 1'b1);
      tick(20);
      checkOutput("loop_valid_count", 32'(valid_cnt), 32'd32);
      checkOutput("loop_ferr_count", 32'(err_cnt), 32'd0);
      for (int i = 0; i < 32; i++) begin
         checkOutput($sformatf("loop_byte%0d", i), 32'(rx_q[i]), 32'((i % 16) + 1));
      end

      // Whole-run pulse properties.
      checkOutput("never_valid_and_ferr", 32'(both_cnt), 32'd0);
      checkOutput("single_cycle_pulses", 32'(double_cnt), 32'd0);
      checkOutput("valid_only_in_idle", 32'(vbusy_cnt), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
# uart_rx

8N1 UART receiver: the receive-side counterpart of the core's UART transmitter, sharing its `bit_period` programming (clocks per bit). It synchronizes the asynchronous serial input and detects the start bit. Each bit is sampled at its midpoint, and each received byte is presented with a one-cycle valid pulse. It sits beside the transmitter in the UART peripheral, behind the same memory-mapped register block.

## Interface
- `SYNC_STAGES`, 2: number of flops in the `serial_in` synchronizer (≥2).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `bit_period` input 16: clocks per bit; latched at start-bit detection.
- `serial_in` input 1: asynchronous serial line; idle high.
- `data` output 8: last correctly framed byte; held until the next good frame.
- `rx_valid` output 1: one-cycle pulse when `data` updates.
- `rx_busy` output 1: high whenever the state is not IDLE.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.

## Operation
- Line is sampled through the `SYNC_STAGES` synchronizer; synchronizer flops and the edge-detect history flop reset to 1.
- Effective period `P` = max(`bit_period`, 4), latched on entry to START. Changes during a frame have no effect. Half period `H` = `P >> 1`.
- A cycle counter is cleared on every state entry and counts up each cycle. A "sample strobe" fires when the counter equals target−1.
- States (enum `uart_rx_state_t`):
  - **IDLE**: on a synchronized falling edge (history 1, current 0) → START. A line held low never retriggers.
  - **START**: target `H`. At the strobe, if the line is 0 → DATA with bit index 0. If it is 1 (glitch) → IDLE, with no output pulse.
  - **DATA**: target `P`. At each strobe, shift the line into bit 7 of the shift register, shifting right (LSB first), and increment the 3-bit index. At the strobe where the index is 7 → STOP.
  - **STOP**: target `P`. At the strobe, if the line is 1, `data` ← shift register and `rx_valid` pulses. If it is 0, `frame_err` pulses and `data` is unchanged. Either way → IDLE.
- Any illegal state encoding → IDLE.
- Reset values: state IDLE, `data` 0x00, `rx_valid` 0, `rx_busy` 0, `frame_err` 0, counter 0, index 0, shift register 0.

## Timing
- Edge-detect latency: a pin falling edge reaches START `SYNC_STAGES`+1 cycles later.
- Start sample occurs `H` cycles after entry to START. Bit *n* is sampled `H` + (*n*+1)·`P` cycles after START entry; the stop bit is sampled at `H` + 9·`P`.
- `rx_valid` / `frame_err` are registered. They are high exactly one cycle, the cycle after the stop-bit strobe, in the same cycle the state reads IDLE.
- `rx_valid` and `frame_err` are never high in the same cycle.
- Back-to-back frames: IDLE is re-entered about `H` cycles before the stop-bit end, so the next start edge is always caught.
- There is no receive handshake. A consumer must capture `data` before the next `rx_valid`; overrun is not flagged.
- Reset mid-frame: the next cycle shows all reset values and no pulse for the aborted frame. The next falling edge after reset starts a fresh frame.

## Structure
- `uart_pkg` (shared with the transmitter) holds:
  - `uart_rx_state_t` (IDLE, START, DATA, STOP; 2 bits)
  - `UART_DATA_BITS` = 8
  - `UART_MIN_BIT_PERIOD` = 4
- Sub-module `uart_sync`: parameterized N-flop synchronizer with a reset value of 1, reusable by other asynchronous inputs.
- The FSM, counter, and datapath live in `uart_rx`. The next-state logic and output logic are separate combinational blocks, plus one registered block.

## Test plan
- `bit_period`=16, transmit 0xA5 (8N1) → exactly one `rx_valid`, `data`=0xA5, `frame_err` 0, `rx_busy` high for ≈ 8+9·16 cycles.
- `bit_period`=16, low glitch of 4 cycles on an idle line → `rx_busy` pulses for ≈ 8 cycles, no `rx_valid`, no `frame_err`, `data` unchanged.
- Receive 0x11, then 0x3C with a low stop bit → one `frame_err` pulse, no `rx_valid`, `data` stays 0x11. With the line then held low for 100 cycles, there is no retrigger until a rising then falling edge.
- Back-to-back 0x00, 0xFF, 0x80 with no idle gap, `bit_period`=10 → three `rx_valid` pulses with the data in order.
- `rst` asserted during data bit 3 of 0xC3 → all outputs at reset values the next cycle. The subsequent 0x5A is received correctly.
- Loopback from the UART transmitter at `bit_period`=8 for bytes 0x01–0x10, then at `bit_period`=2 (clamped to 4 on both ends) → all bytes match, zero `frame_err`.
